mlp_seq_core: RTL and testbench

MLP_SEQ_CORE -- requirements
Module: mlp_seq_core

---
 rtl/mlp_seq_pkg.sv | 35 +++
 rtl/mlp_mac.sv | 43 ++++
 rtl/mlp_seq_core.sv | 228 ++++++++++++++++++++++
 tb/tb_mlp_seq_core.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_seq_pkg.sv
// Shared definitions for the sequential two-layer MLP core: FSM encoding,
// default sizing and the weight/bias address map helpers.
package mlp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_L1_MAC = 3'd1,
    S_L1_ACT = 3'd2,
    S_L2_MAC = 3'd3,
    S_L2_WR  = 3'd4,
    S_ARGMAX = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam int DEF_N_IN  = 784;
  localparam int DEF_N_HID = 32;
  localparam int DEF_N_OUT = 10;
  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 32;
  localparam int DEF_SHIFT = 7;

  // Layer-2 weights follow all layer-1 weights; layer-2 biases follow layer-1 biases.
  function automatic int l1_w_addr(input int n_in, input int h, input int i);
    return h * n_in + i;
  endfunction

  function automatic int l2_w_addr(input int n_in, input int n_hid, input int o, input int h);
    return n_hid * n_in + o * n_hid + h;
  endfunction

  function automatic int l2_b_addr(input int n_hid, input int o);
    return n_hid + o;
  endfunction

endpackage

// File: rtl/mlp_mac.sv
// Signed multiply-accumulate: loads bias plus the first product, then adds
// further products, wrapping in two's complement at AW bits.
module mlp_mac #(
  parameter int DW = 8,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          accum,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [AW-1:0] bias,
  output logic [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic [AW-1:0]          acc_q, acc_d;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = bias + prod_ext;
    end else if (accum) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mlp_seq_core.sv
// Sequential MLP inference engine: one MAC walks layer 1 from external
// memories, then layer 2 from the hidden register file, then an argmax scan.
module mlp_seq_core
  import mlp_seq_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_HID = DEF_N_HID,
  parameter int N_OUT = DEF_N_OUT,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int SHIFT = DEF_SHIFT,
  localparam int IN_AW = $clog2(N_IN),
  localparam int W_AW  = $clog2(N_HID*N_IN + N_OUT*N_HID),
  localparam int B_AW  = $clog2(N_HID + N_OUT),
  localparam int C_AW  = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [IN_AW-1:0] in_addr,
  input  logic [DW-1:0]    in_data,
  output logic [W_AW-1:0]  w_addr,
  input  logic [DW-1:0]    w_data,
  output logic [B_AW-1:0]  b_addr,
  input  logic [AW-1:0]    b_data,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic [C_AW-1:0]  res_class,
  output logic [AW-1:0]    res_score,
  output logic [2:0]       state_o,
  output logic [31:0]      cyc_count
);

  localparam int KMAX = (N_IN > N_HID) ? ((N_IN > N_OUT) ? N_IN : N_OUT)
                                       : ((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam int CW   = $clog2(KMAX + 2);
  localparam int NW   = $clog2(((N_HID > N_OUT) ? N_HID : N_OUT) + 1);
  localparam int HW   = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int OW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [DW-1:0] ACT_MAX = DW'((1 << (DW-1)) - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [NW-1:0]   nrn_q, nrn_d;
  logic [DW-1:0]   hid_q [N_HID];
  logic [DW-1:0]   hid_d [N_HID];
  logic [AW-1:0]   score_q [N_OUT];
  logic [AW-1:0]   score_d [N_OUT];
  logic [DW-1:0]   hid_rd_q, hid_rd_d;
  logic [AW-1:0]   best_q, best_d;
  logic [C_AW-1:0] best_cls_q, best_cls_d;
  logic            res_valid_q, res_valid_d;
  logic [C_AW-1:0] res_class_q, res_class_d;
  logic [AW-1:0]   res_score_q, res_score_d;
  logic [31:0]     cyc_q, cyc_d;

  logic            in_mac, mac_load, mac_accum;
  logic [DW-1:0]   mac_a;
  logic [AW-1:0]   acc, acc_sh, score_cur;
  logic [DW-1:0]   act_val;

  // Element 0 data arrives in MAC cycle 1, which therefore loads the bias.
  assign in_mac    = (state_q == S_L1_MAC) || (state_q == S_L2_MAC);
  assign mac_load  = in_mac && (idx_q == CW'(1));
  assign mac_accum = in_mac && (idx_q > CW'(1));
  assign mac_a     = (state_q == S_L2_MAC) ? hid_rd_q : in_data;

  mlp_mac #(.DW(DW), .AW(AW)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mac_load),
    .accum (mac_accum),
    .a     (mac_a),
    .b     (w_data),
    .bias  (b_data),
    .acc   (acc)
  );

  assign acc_sh    = acc >> SHIFT;
  assign score_cur = score_q[OW'(idx_q)];

  always_comb begin
    act_val = '0;
    if (!acc[AW-1]) begin
      act_val = (acc_sh > AW'(ACT_MAX)) ? ACT_MAX : acc_sh[DW-1:0];
    end
  end

  always_comb begin
    in_addr  = '0;
    w_addr   = '0;
    b_addr   = '0;
    hid_rd_d = hid_rd_q;
    unique case (state_q)
      S_L1_MAC: begin
        b_addr = B_AW'(nrn_q);
        if (idx_q < CW'(N_IN)) begin
          in_addr = IN_AW'(idx_q);
          w_addr  = W_AW'(l1_w_addr(N_IN, int'(nrn_q), int'(idx_q)));
        end
      end
      S_L2_MAC: begin
        b_addr = B_AW'(l2_b_addr(N_HID, int'(nrn_q)));
        if (idx_q < CW'(N_HID)) begin
          w_addr   = W_AW'(l2_w_addr(N_IN, N_HID, int'(nrn_q), int'(idx_q)));
          hid_rd_d = hid_q[HW'(idx_q)];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    nrn_d       = nrn_q;
    hid_d       = hid_q;
    score_d     = score_q;
    best_d      = best_q;
    best_cls_d  = best_cls_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    res_score_d = res_score_q;
    cyc_d       = (state_q != S_IDLE) ? cyc_q + 32'd1 : cyc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d     = S_L1_MAC;
          idx_d       = '0;
          nrn_d       = '0;
          cyc_d       = '0;
          res_valid_d = 1'b0;
        end
      end
      S_L1_MAC: begin
        idx_d = idx_q + CW'(1);
        if (idx_q == CW'(N_IN)) state_d = S_L1_ACT;
      end
      S_L1_ACT: begin
        hid_d[HW'(nrn_q)] = act_val;
        idx_d = '0;
        if (nrn_q == NW'(N_HID-1)) begin
          nrn_d   = '0;
          state_d = S_L2_MAC;
        end else begin
          nrn_d   = nrn_q + NW'(1);
          state_d = S_L1_MAC;
        end
      end
      S_L2_MAC: begin
        idx_d = idx_q + CW'(1);
        if (idx_q == CW'(N_HID)) state_d = S_L2_WR;
      end
      S_L2_WR: begin
        score_d[OW'(nrn_q)] = acc;
        idx_d = '0;
        if (nrn_q == NW'(N_OUT-1)) begin
          nrn_d   = '0;
          state_d = S_ARGMAX;
        end else begin
          nrn_d   = nrn_q + NW'(1);
          state_d = S_L2_MAC;
        end
      end
      S_ARGMAX: begin
        idx_d = idx_q + CW'(1);
        // Strictly greater keeps the lowest index on ties.
        if ((idx_q == '0) || ($signed(score_cur) > $signed(best_q))) begin
          best_d     = score_cur;
          best_cls_d = C_AW'(idx_q);
        end
        if (idx_q == CW'(N_OUT-1)) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
          res_class_d = best_cls_d;
          res_score_d = best_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      nrn_q       <= '0;
      for (int i = 0; i < N_HID; i++) hid_q[i] <= '0;
      for (int i = 0; i < N_OUT; i++) score_q[i] <= '0;
      hid_rd_q    <= '0;
      best_q      <= '0;
      best_cls_q  <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_score_q <= '0;
      cyc_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      nrn_q       <= nrn_d;
      hid_q       <= hid_d;
      score_q     <= score_d;
      hid_rd_q    <= hid_rd_d;
      best_q      <= best_d;
      best_cls_q  <= best_cls_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_score_q <= res_score_d;
      cyc_q       <= cyc_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_score = res_score_q;
  assign state_o   = state_q;
  assign cyc_count = cyc_q;

endmodule

// File: tb/tb_mlp_seq_core.sv
// Directed and randomized checks of mlp_seq_core against an arithmetic
// reference of the two-layer network on small parameters.
module tb_mlp_seq_core;

  localparam int N_IN  = 4;
  localparam int N_HID = 2;
  localparam int N_OUT = 3;
  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int SHIFT = 0;
  localparam int NWT   = N_HID*N_IN + N_OUT*N_HID;
  localparam int NB    = N_HID + N_OUT;
  localparam int LAT   = N_HID*(N_IN+2) + N_OUT*(N_HID+2) + N_OUT + 1;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic [$clog2(N_IN)-1:0]  in_addr;
  logic [$clog2(NWT)-1:0]   w_addr;
  logic [$clog2(NB)-1:0]    b_addr;
  logic [DW-1:0]            in_data, w_data;
  logic [AW-1:0]            b_data;
  logic                     busy, done, res_valid;
  logic [$clog2(N_OUT)-1:0] res_class;
  logic [AW-1:0]            res_score;
  logic [2:0]               state_o;
  logic [31:0]              cyc_count;

  int in_mem [N_IN];
  int w_mem  [NWT];
  int b_mem  [NB];

  int compared   = 0;
  int mismatched = 0;

  mlp_seq_core #(
    .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .AW(AW), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_addr(in_addr), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data),
    .busy(busy), .done(done), .res_valid(res_valid),
    .res_class(res_class), .res_score(res_score),
    .state_o(state_o), .cyc_count(cyc_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) begin
    in_data <= DW'(in_mem[in_addr]);
    w_data  <= DW'(w_mem[w_addr]);
    b_data  <= AW'(b_mem[b_addr]);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void loadNominal();
    for (int i = 0; i < N_IN; i++) in_mem[i] = i + 1;
    for (int i = 0; i < NWT; i++) w_mem[i] = 1;
    for (int i = 0; i < NB; i++) b_mem[i] = 0;
  endfunction

  // Reference network: ReLU, shift, clamp for layer 1; raw scores and a
  // first-wins maximum for layer 2.
  function automatic void refModel(output int cls, output int scr);
    int hid [N_HID];
    int sc  [N_OUT];
    int acc;
    for (int h = 0; h < N_HID; h++) begin
      acc = b_mem[h];
      for (int i = 0; i < N_IN; i++) acc += in_mem[i] * w_mem[h*N_IN + i];
      hid[h] = (acc < 0) ? 0 : (acc >>> SHIFT);
      if (hid[h] > 127) hid[h] = 127;
    end
    for (int o = 0; o < N_OUT; o++) begin
      sc[o] = b_mem[N_HID + o];
      for (int h = 0; h < N_HID; h++) sc[o] += hid[h] * w_mem[N_HID*N_IN + o*N_HID + h];
    end
    cls = 0;
    scr = sc[0];
    for (int o = 1; o < N_OUT; o++) begin
      if (sc[o] > scr) begin
        scr = sc[o];
        cls = o;
      end
    end
  endfunction

  // Pulses start and watches a fixed window; cycle n is n edges after the start cycle.
  task automatic applyStimulus(input int extra_at, output int lat, output int pulses,
                               output logic [31:0] cls, output logic [31:0] scr, output logic vld);
    int n;
    lat = -1; pulses = 0; cls = '0; scr = '0; vld = 1'b0; n = 0;
    start = 1'b1;
    while (n < LAT + 12) begin
      @(posedge clk); #1;
      n++;
      start = (n == extra_at);
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          cls = 32'(res_class);
          scr = res_score;
          vld = res_valid;
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, pulses, n, ecls, escr;
    logic [31:0] cls, scr;
    logic vld;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    loadNominal();
    #12;
    checkOutput("reset_state", 32'(state_o), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_valid", 32'(res_valid), 32'd0);
    checkOutput("reset_cyc", cyc_count, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] nominal run");
    applyStimulus(0, lat, pulses, cls, scr, vld);
    checkOutput("nom_latency", 32'(lat), 32'd28);
    checkOutput("nom_pulses", 32'(pulses), 32'd1);
    checkOutput("nom_class", cls, 32'd0);
    checkOutput("nom_score", scr, 32'd20);
    checkOutput("nom_valid_at_done", 32'(vld), 32'd1);
    checkOutput("nom_cyc_count", cyc_count, 32'd28);
    checkOutput("nom_valid_held", 32'(res_valid), 32'd1);
    checkOutput("nom_idle_busy", 32'(busy), 32'd0);

    $display("[TB] distinct scores");
    for (int h = 0; h < N_HID; h++) w_mem[N_HID*N_IN + 2*N_HID + h] = 2;
    applyStimulus(0, lat, pulses, cls, scr, vld);
    checkOutput("dist_class", cls, 32'd2);
    checkOutput("dist_score", scr, 32'd40);

    $display("[TB] relu and saturation");
    loadNominal();
    b_mem[0] = -100;
    b_mem[1] = 500;
    w_mem[N_HID*N_IN + 1*N_HID + 0] = -1;
    w_mem[N_HID*N_IN + 1*N_HID + 1] = 2;
    applyStimulus(0, lat, pulses, cls, scr, vld);
    checkOutput("relu_class", cls, 32'd1);
    checkOutput("relu_score", scr, 32'd254);

    $display("[TB] abort mid-run");
    loadNominal();
    start = 1'b1; n = 0;
    while (n < 10) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
    end
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_state", 32'(state_o), 32'd0);
    checkOutput("abort_valid", 32'(res_valid), 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checkOutput("abort_no_done", 32'(pulses), 32'd0);

    $display("[TB] start with abort in idle");
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checkOutput("idle_abort_start", 32'(state_o), 32'd0);

    $display("[TB] reset mid-run");
    applyStimulus(0, lat, pulses, cls, scr, vld);
    start = 1'b1; n = 0;
    while (n < 15) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cyc", cyc_count, 32'd0);
    checkOutput("rst_score", res_score, 32'd0);
    checkOutput("rst_w_addr", 32'(w_addr), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_stays_idle", 32'(state_o), 32'd0);
    applyStimulus(0, lat, pulses, cls, scr, vld);
    checkOutput("rst_rerun_latency", 32'(lat), 32'd28);
    checkOutput("rst_rerun_class", cls, 32'd0);
    checkOutput("rst_rerun_score", scr, 32'd20);

    $display("[TB] start ignored while busy");
    applyStimulus(5, lat, pulses, cls, scr, vld);
    checkOutput("restart_latency", 32'(lat), 32'd28);
    checkOutput("restart_pulses", 32'(pulses), 32'd1);
    checkOutput("restart_score", scr, 32'd20);

    $display("[TB] randomized vectors");
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N_IN; i++) in_mem[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < NWT; i++) w_mem[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < NB; i++) b_mem[i] = int'($urandom_range(0, 8000)) - 4000;
      refModel(ecls, escr);
      applyStimulus(0, lat, pulses, cls, scr, vld);
      checkOutput($sformatf("rand%0d_latency", t), 32'(lat), 32'(LAT));
      checkOutput($sformatf("rand%0d_class", t), cls, 32'(ecls));
      checkOutput($sformatf("rand%0d_score", t), scr, 32'(escr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
